// File: rtl/phys_reg_free_list_pkg.sv
// Shared rename package: physical register file sizing and the tag type,
// common to the free list and the ready-bit table.
package phys_reg_free_list_pkg;

    localparam int unsigned NUM_PHYS_DEF = 64;
    localparam int unsigned TAG_W_DEF    = 6;
    localparam int unsigned NUM_ARCH_DEF = 32;
    localparam int unsigned SLOTS        = 4;
    localparam int unsigned OFF_W        = 3;

    typedef logic [TAG_W_DEF-1:0] phys_tag_t;

endpackage : phys_reg_free_list_pkg

// File: rtl/phys_reg_free_list_compact.sv
// Four-slot prefix popcount: offset of each set slot among the set slots
// before it, plus the total. Used for alloc read offsets and free packing.
module free_list_compact
    import phys_reg_free_list_pkg::*;
(
    input  logic [0:3]                  vec_i,
    output logic [SLOTS-1:0][OFF_W-1:0] offset_o,
    output logic [OFF_W-1:0]            total_o
);

    // Running exclusive prefix sum over slots 0..3
    always_comb begin
        logic [OFF_W-1:0] acc;
        acc      = '0;
        offset_o = '0;
        for (int i = 0; i < 4; i++) begin
            offset_o[i] = acc;
            acc         = acc + OFF_W'(vec_i[i]);
        end
        total_o = acc;
    end

endmodule : free_list_compact

// File: rtl/phys_reg_free_list.sv
// Physical register free list: circular buffer of free tags with 4-wide
// allocate and 4-wide release per cycle.
// Optional feature macro: FREE_LIST_RESTORE_EN adds checkpoint/restore of
// the head pointer through a shadow register.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
#(
    parameter int unsigned NUM_PHYS = NUM_PHYS_DEF,
    parameter int unsigned TAG_W    = TAG_W_DEF,
    parameter int unsigned NUM_ARCH = NUM_ARCH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [0:3]       allocReq,
    output logic [TAG_W-1:0] allocTag0,
    output logic [TAG_W-1:0] allocTag1,
    output logic [TAG_W-1:0] allocTag2,
    output logic [TAG_W-1:0] allocTag3,
    output logic             allocStall,
    input  logic [0:3]       freeEn,
    input  logic [TAG_W-1:0] freeTag0,
    input  logic [TAG_W-1:0] freeTag1,
    input  logic [TAG_W-1:0] freeTag2,
    input  logic [TAG_W-1:0] freeTag3,
`ifdef FREE_LIST_RESTORE_EN
    input  logic             checkpoint,
    input  logic             restore,
`endif
    output logic [TAG_W:0]   freeCount,
    output logic             overflowErr
);

    localparam int unsigned CNT_W = TAG_W + 1;
    localparam int unsigned SUM_W = TAG_W + 2;

    logic [TAG_W-1:0] mem_q [NUM_PHYS];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic [TAG_W-1:0]             free_tag [SLOTS];
    logic [0:3]                   free_vld;
    logic [SLOTS-1:0][OFF_W-1:0]  a_off, f_off;
    logic [OFF_W-1:0]             a_tot, f_tot;
    logic [0:3]                   accept;
    logic [TAG_W-1:0]             wr_idx [SLOTS];
    logic [OFF_W-1:0]             n_acc;
    logic [CNT_W-1:0]             base;
    logic [CNT_W-1:0]             room;
    logic                         alloc_go;

    // Pointer advance modulo NUM_PHYS
    function automatic logic [TAG_W-1:0] ptr_add(input logic [TAG_W-1:0] p,
                                                  input logic [OFF_W-1:0] o);
        logic [SUM_W-1:0] s;
        s = SUM_W'(p) + SUM_W'(o);
        if (s >= SUM_W'(NUM_PHYS)) s = s - SUM_W'(NUM_PHYS);
        return TAG_W'(s);
    endfunction

    assign free_tag[0] = freeTag0;
    assign free_tag[1] = freeTag1;
    assign free_tag[2] = freeTag2;
    assign free_tag[3] = freeTag3;

    // Tag p0 is never renamed, so releasing it is a no-op
    always_comb begin
        free_vld = '0;
        for (int i = 0; i < 4; i++) begin
            free_vld[i] = freeEn[i] && (free_tag[i] != '0);
        end
    end

    free_list_compact u_alloc_cmp (
        .vec_i    (allocReq),
        .offset_o (a_off),
        .total_o  (a_tot)
    );

    free_list_compact u_free_cmp (
        .vec_i    (free_vld),
        .offset_o (f_off),
        .total_o  (f_tot)
    );

    assign allocStall = CNT_W'(a_tot) > count_q;
    assign allocTag0  = mem_q[ptr_add(head_q, a_off[0])];
    assign allocTag1  = mem_q[ptr_add(head_q, a_off[1])];
    assign allocTag2  = mem_q[ptr_add(head_q, a_off[2])];
    assign allocTag3  = mem_q[ptr_add(head_q, a_off[3])];
    assign freeCount  = count_q;
    assign overflowErr = ovf_q;

`ifdef FREE_LIST_RESTORE_EN
    logic [TAG_W-1:0] shadow_q;
    logic [CNT_W-1:0] restore_count;

    // Occupancy implied by rewinding head to the shadow; an equal-pointer
    // rewind from a non-empty list can only mean the list is full
    always_comb begin
        logic [SUM_W-1:0] diff;
        diff = SUM_W'(tail_q) + SUM_W'(NUM_PHYS) - SUM_W'(shadow_q);
        if (diff >= SUM_W'(NUM_PHYS)) diff = diff - SUM_W'(NUM_PHYS);
        if (diff == '0 && count_q != '0) restore_count = CNT_W'(NUM_PHYS);
        else                             restore_count = CNT_W'(diff);
    end

    // Shadow head capture on checkpoint
    always_ff @(posedge clk) begin
        if (reset)                 shadow_q <= '0;
        else if (en && checkpoint) shadow_q <= head_q;
    end
`endif

    // Next head/tail/count: allocation (or restore) first, then releases
    // packed into whatever room remains, dropping the highest slots
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        accept   = '0;
        n_acc    = '0;
        alloc_go = !allocStall;
        base     = count_q;
        for (int i = 0; i < 4; i++) wr_idx[i] = ptr_add(tail_q, f_off[i]);
`ifdef FREE_LIST_RESTORE_EN
        if (restore) begin
            alloc_go = 1'b0;
            head_d   = shadow_q;
            base     = restore_count;
        end
`endif
        if (alloc_go) begin
            head_d = ptr_add(head_q, a_tot);
            base   = count_q - CNT_W'(a_tot);
        end
        room = CNT_W'(NUM_PHYS) - base;
        for (int i = 0; i < 4; i++) begin
            if (free_vld[i] && (CNT_W'(f_off[i]) < room)) begin
                accept[i] = 1'b1;
                n_acc     = n_acc + OFF_W'(1);
            end
        end
        tail_d  = ptr_add(tail_q, n_acc);
        count_d = base + CNT_W'(n_acc);
        if (f_tot != n_acc) ovf_d = 1'b1;
    end

    // Pointer, count and sticky overflow registers
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= TAG_W'(NUM_PHYS - NUM_ARCH);
            count_q <= CNT_W'(NUM_PHYS - NUM_ARCH);
            ovf_q   <= 1'b0;
        end else if (en) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Tag storage: reset holds the unmapped tags, releases write at tail
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_PHYS; k++) begin
                if (k < NUM_PHYS - NUM_ARCH) mem_q[k] <= TAG_W'(NUM_ARCH + k);
                else                         mem_q[k] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (accept[i]) mem_q[wr_idx[i]] <= free_tag[i];
            end
        end
    end

endmodule : phys_reg_free_list

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list (default 64/6/32 configuration).
module tb_phys_reg_free_list;

    logic       clk;
    logic       reset;
    logic       en;
    logic [0:3] allocReq;
    logic [5:0] allocTag0, allocTag1, allocTag2, allocTag3;
    logic       allocStall;
    logic [0:3] freeEn;
    logic [5:0] freeTag0, freeTag1, freeTag2, freeTag3;
    logic [6:0] freeCount;
    logic       overflowErr;
`ifdef FREE_LIST_RESTORE_EN
    logic       checkpoint;
    logic       restore;
`endif

    int n_cmp = 0;
    int n_err = 0;

    phys_reg_free_list dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .allocReq    (allocReq),
        .allocTag0   (allocTag0),
        .allocTag1   (allocTag1),
        .allocTag2   (allocTag2),
        .allocTag3   (allocTag3),
        .allocStall  (allocStall),
        .freeEn      (freeEn),
        .freeTag0    (freeTag0),
        .freeTag1    (freeTag1),
        .freeTag2    (freeTag2),
        .freeTag3    (freeTag3),
`ifdef FREE_LIST_RESTORE_EN
        .checkpoint  (checkpoint),
        .restore     (restore),
`endif
        .freeCount   (freeCount),
        .overflowErr (overflowErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b1; allocReq = 4'b0000; freeEn = 4'b0000;
        freeTag0 = '0; freeTag1 = '0; freeTag2 = '0; freeTag3 = '0;
`ifdef FREE_LIST_RESTORE_EN
        checkpoint = 1'b0; restore = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (freeCount !== 7'd32) begin
            n_err++; $display("FAIL reset_count got %0d want 32", freeCount);
        end
        n_cmp++;
        if (overflowErr !== 1'b0) begin
            n_err++; $display("FAIL reset_ovf got %0b want 0", overflowErr);
        end
        allocReq = 4'b1111;
        #1;
        n_cmp++;
        if ({allocTag0, allocTag1, allocTag2, allocTag3} !== {6'd32, 6'd33, 6'd34, 6'd35}
            || allocStall !== 1'b0) begin
            n_err++;
            $display("FAIL alloc4_tags got %0d %0d %0d %0d stall %0b want 32 33 34 35 stall 0",
                     allocTag0, allocTag1, allocTag2, allocTag3, allocStall);
        end
        tick();
        allocReq = 4'b0000;
        n_cmp++;
        if (freeCount !== 7'd28) begin
            n_err++; $display("FAIL alloc4_count got %0d want 28", freeCount);
        end
    endtask

    task automatic test_sparse();
        do_reset();
        allocReq = 4'b1010;
        #1;
        n_cmp++;
        if (allocTag0 !== 6'd32 || allocTag2 !== 6'd33) begin
            n_err++; $display("FAIL sparse_tags got %0d %0d want 32 33", allocTag0, allocTag2);
        end
        tick();
        allocReq = 4'b1000;
        #1;
        n_cmp++;
        if (allocTag0 !== 6'd34 || freeCount !== 7'd30) begin
            n_err++; $display("FAIL sparse_head got tag %0d count %0d want 34 30", allocTag0, freeCount);
        end
        allocReq = 4'b0000;
    endtask

    task automatic test_stall();
        do_reset();
        allocReq = 4'b1111;
        for (int k = 0; k < 7; k++) tick();
        allocReq = 4'b1100;
        tick();
        allocReq = 4'b0111;
        #1;
        n_cmp++;
        if (freeCount !== 7'd2 || allocStall !== 1'b1) begin
            n_err++; $display("FAIL stall_flag got count %0d stall %0b want 2 1", freeCount, allocStall);
        end
        tick();
        allocReq = 4'b1000;
        #1;
        n_cmp++;
        if (freeCount !== 7'd2 || allocTag0 !== 6'd62) begin
            n_err++; $display("FAIL stall_hold got count %0d tag %0d want 2 62", freeCount, allocTag0);
        end
        en = 1'b0;
        tick();
        en = 1'b1;
        n_cmp++;
        if (freeCount !== 7'd2 || allocTag0 !== 6'd62) begin
            n_err++; $display("FAIL en_low got count %0d tag %0d want 2 62", freeCount, allocTag0);
        end
        allocReq = 4'b0000;
    endtask

    // Continues from the two-entry state left by test_stall
    task automatic test_simultaneous();
        allocReq = 4'b1100;
        #1;
        n_cmp++;
        if (allocTag0 !== 6'd62 || allocTag1 !== 6'd63) begin
            n_err++; $display("FAIL last_two got %0d %0d want 62 63", allocTag0, allocTag1);
        end
        tick();
        allocReq = 4'b0001; freeEn = 4'b1000; freeTag0 = 6'd5;
        #1;
        n_cmp++;
        if (freeCount !== 7'd0 || allocStall !== 1'b1) begin
            n_err++; $display("FAIL empty_stall got count %0d stall %0b want 0 1", freeCount, allocStall);
        end
        tick();
        freeEn = 4'b0000; freeTag0 = '0;
        #1;
        n_cmp++;
        if (freeCount !== 7'd1 || allocStall !== 1'b0 || allocTag3 !== 6'd5) begin
            n_err++;
            $display("FAIL refill_alloc got count %0d stall %0b tag %0d want 1 0 5",
                     freeCount, allocStall, allocTag3);
        end
        tick();
        allocReq = 4'b0000;
        n_cmp++;
        if (freeCount !== 7'd0) begin
            n_err++; $display("FAIL refill_drain got %0d want 0", freeCount);
        end
    endtask

    task automatic test_filter_overflow();
        logic [5:0] exp_t [4];
        do_reset();
        freeEn = 4'b1000; freeTag0 = 6'd0;
        tick();
        n_cmp++;
        if (freeCount !== 7'd32) begin
            n_err++; $display("FAIL zero_filter got %0d want 32", freeCount);
        end
        // release tags 1..30 to reach 62 free
        for (int k = 0; k < 8; k++) begin
            freeEn   = (k == 7) ? 4'b1100 : 4'b1111;
            freeTag0 = 6'(4 * k + 1);
            freeTag1 = 6'(4 * k + 2);
            freeTag2 = 6'(4 * k + 3);
            freeTag3 = 6'(4 * k + 4);
            tick();
        end
        n_cmp++;
        if (freeCount !== 7'd62 || overflowErr !== 1'b0) begin
            n_err++; $display("FAIL fill_62 got count %0d ovf %0b want 62 0", freeCount, overflowErr);
        end
        freeEn = 4'b1111;
        freeTag0 = 6'd40; freeTag1 = 6'd41; freeTag2 = 6'd42; freeTag3 = 6'd43;
        tick();
        idle();
        n_cmp++;
        if (freeCount !== 7'd64 || overflowErr !== 1'b1) begin
            n_err++; $display("FAIL overflow got count %0d ovf %0b want 64 1", freeCount, overflowErr);
        end
        // drain everything; check buffer order at a few points
        allocReq = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (k == 0 || k == 8 || k == 15) begin
                if (k == 0) begin
                    exp_t[0] = 6'd32; exp_t[1] = 6'd33; exp_t[2] = 6'd34; exp_t[3] = 6'd35;
                end else if (k == 8) begin
                    exp_t[0] = 6'd1; exp_t[1] = 6'd2; exp_t[2] = 6'd3; exp_t[3] = 6'd4;
                end else begin
                    exp_t[0] = 6'd29; exp_t[1] = 6'd30; exp_t[2] = 6'd40; exp_t[3] = 6'd41;
                end
                n_cmp++;
                if (allocTag0 !== exp_t[0] || allocTag1 !== exp_t[1] ||
                    allocTag2 !== exp_t[2] || allocTag3 !== exp_t[3]) begin
                    n_err++;
                    $display("FAIL drain_order step %0d got %0d %0d %0d %0d want %0d %0d %0d %0d",
                             k, allocTag0, allocTag1, allocTag2, allocTag3,
                             exp_t[0], exp_t[1], exp_t[2], exp_t[3]);
                end
            end
            tick();
        end
        allocReq = 4'b0000;
        n_cmp++;
        if (freeCount !== 7'd0 || overflowErr !== 1'b1) begin
            n_err++; $display("FAIL ovf_sticky got count %0d ovf %0b want 0 1", freeCount, overflowErr);
        end
        do_reset();
        n_cmp++;
        if (overflowErr !== 1'b0) begin
            n_err++; $display("FAIL ovf_clear got %0b want 0", overflowErr);
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        allocReq = 4'b1111;
        tick();
        allocReq = 4'b1111; freeEn = 4'b1111;
        freeTag0 = 6'd7; freeTag1 = 6'd8; freeTag2 = 6'd9; freeTag3 = 6'd10;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        allocReq = 4'b1000;
        #1;
        n_cmp++;
        if (freeCount !== 7'd32 || allocTag0 !== 6'd32) begin
            n_err++; $display("FAIL reset_prio got count %0d tag %0d want 32 32", freeCount, allocTag0);
        end
        allocReq = 4'b0000;
    endtask

`ifdef FREE_LIST_RESTORE_EN
    task automatic test_restore();
        do_reset();
        allocReq = 4'b1000;
        tick();
        allocReq = 4'b0000; checkpoint = 1'b1;
        tick();
        checkpoint = 1'b0; allocReq = 4'b1111;
        tick();
        n_cmp++;
        if (freeCount !== 7'd27) begin
            n_err++; $display("FAIL ckpt_alloc got %0d want 27", freeCount);
        end
        restore = 1'b1;
        tick();
        restore = 1'b0;
        #1;
        n_cmp++;
        if (freeCount !== 7'd31 || {allocTag0, allocTag1, allocTag2, allocTag3} !==
            {6'd33, 6'd34, 6'd35, 6'd36}) begin
            n_err++;
            $display("FAIL restore got count %0d tags %0d %0d %0d %0d want 31 33 34 35 36",
                     freeCount, allocTag0, allocTag1, allocTag2, allocTag3);
        end
        allocReq = 4'b0000;
    endtask
`endif

    initial begin
        reset = 1'b0;
        idle();
        test_reset();
        test_sparse();
        test_stall();
        test_simultaneous();
        test_filter_overflow();
        test_reset_priority();
`ifdef FREE_LIST_RESTORE_EN
        test_restore();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_phys_reg_free_list

// File: doc/phys_reg_free_list.md
PHYS_REG_FREE_LIST -- requirements
Module: phys_reg_free_list

Interface
REQ-001 SHALL have parameter NUM_PHYS, default 64, number of physical registers.
REQ-002 SHALL have parameter TAG_W, default 6, physical tag width (log2 NUM_PHYS).
REQ-003 SHALL have parameter NUM_ARCH, default 32, count of tags p0..p(NUM_ARCH-1) mapped at reset.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high.
REQ-006 SHALL have port en  in  1  global enable; when 0, no state change.
REQ-007 SHALL have port allocReq  in  [0:3]  per-slot request for a new physical tag.
REQ-008 SHALL have ports allocTag0..allocTag3  out  TAG_W each  tag granted to slot i.
REQ-009 SHALL have port allocStall  out  1  requested count exceeds free count; nothing granted.
REQ-010 SHALL have port freeEn  in  [0:3]  per-slot release of a committed-dead tag.
REQ-011 SHALL have ports freeTag0..freeTag3  in  TAG_W each  tag released by slot i.
REQ-012 SHALL have port freeCount  out  TAG_W+1  number of tags currently free.
REQ-013 SHALL have port overflowErr  out  1  sticky: release attempted into a full list.

Function
REQ-014 SHALL store free tags in a circular buffer of NUM_PHYS entries with head, tail pointers (TAG_W bits) and count (TAG_W+1 bits).
REQ-015 SHALL compute allocTag i combinationally as entry[head + popcount(allocReq[0..i-1])], wrapping mod NUM_PHYS; value for unrequested slots is don't-care.
REQ-016 SHALL assert allocStall combinationally when popcount(allocReq) > count; allocation all-or-nothing.
REQ-017 SHALL, on clk edge with en=1 and allocStall=0, advance head by popcount(allocReq).
REQ-018 SHALL ignore freeEn[i] when freeTag i == 0 (p0 never renamed).
REQ-019 SHALL append valid released tags at tail in slot order 0..3, compacted, advancing tail by their number.
REQ-020 SHALL apply alloc and free in same cycle: allocation sees pre-cycle contents; count_next = count - allocs + frees.
REQ-021 SHALL, if count - allocs + frees would exceed NUM_PHYS, drop excess releases (highest slots first) and set overflowErr until reset.
REQ-022 SHALL drive freeCount from the count register (registered, one-cycle visibility of updates).
REQ-023 SHALL perform no duplicate-tag detection; uniqueness is the caller's responsibility.

Reset
REQ-024 SHALL on reset load entry[k] = NUM_ARCH + k for k < NUM_PHYS - NUM_ARCH, head=0, tail=NUM_PHYS-NUM_ARCH, count=NUM_PHYS-NUM_ARCH, overflowErr=0.
REQ-025 SHALL give reset priority over en, alloc, free and restore; reset mid-operation discards all pending requests.

Configuration
REQ-026 SHALL, with FREE_LIST_RESTORE_EN defined, add ports checkpoint (in 1) and restore (in 1), saving head into a shadow register on checkpoint and reloading head from shadow on restore (count recomputed from tail minus head mod wrap).
REQ-027 SHALL give restore priority over allocation in the same cycle; frees still apply.
REQ-028 SHALL, without FREE_LIST_RESTORE_EN, omit checkpoint/restore ports and shadow register entirely.

Structure
REQ-029 SHALL take NUM_PHYS, TAG_W, NUM_ARCH defaults and the tag typedef from the shared rename package, common with the ready-bit table.
REQ-030 SHALL implement the 4-input prefix popcount/compaction as sub-module free_list_compact, used for both alloc offsets and free packing.

Verification
REQ-031 SHALL check reset: freeCount=32; allocReq=1111 -> tags 32,33,34,35, freeCount=28 next cycle.
REQ-032 SHALL check sparse alloc: allocReq=1010 after reset -> allocTag0=32, allocTag2=33, head advances by 2.
REQ-033 SHALL check stall: drain to count=2, allocReq=0111 -> allocStall=1, head and count unchanged.
REQ-034 SHALL check simultaneous: count=0, allocReq=0001 with freeEn=1000 freeTag0=5 -> allocStall=1; next cycle alloc gives 5.
REQ-035 SHALL check filtering/overflow: freeTag=0 ignored; free 4 tags at count=62 -> 2 appended, overflowErr=1 sticky.
REQ-036 SHALL check restore (macro on): checkpoint, allocate 4, restore -> head returns, same 4 tags re-granted.
